// File: rtl/bcd_uart_pkg.sv
// Shared constants, state encoding and the digit-to-ASCII mapping for the
// BCD UART transmitter.
package bcd_uart_pkg;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_BAD  = 8'h3F;
  localparam logic [7:0] ASCII_CR   = 8'h0D;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, NEXT} tx_state_t;

  // '0'..'9' for valid BCD, '?' for anything above 9
  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_BAD : (ASCII_ZERO + {4'h0, d});
  endfunction

endpackage

// File: rtl/bcd_uart_tx_if.sv
// Number/control inputs and UART/status outputs of the BCD transmitter.
interface bcd_uart_tx_if #(parameter int DIGITS = 8);

  logic [DIGITS-1:0][3:0] i_num;
  logic                   i_start;
  logic                   i_auto_en;
  logic                   o_tx;
  logic                   o_busy;
  logic                   o_done;
  logic                   o_bad;

  modport master (output i_num, i_start, i_auto_en,
                  input  o_tx, o_busy, o_done, o_bad);
  modport slave  (input  i_num, i_start, i_auto_en,
                  output o_tx, o_busy, o_done, o_bad);

endinterface

// File: rtl/uart_byte_tx.sv
// Single-byte 8N1 UART serialiser. A byte offered while ready starts its
// start bit on the next cycle. After the stop bit one NEXT cycle follows
// in which a new byte may be accepted, giving a one-cycle inter-byte gap.
module uart_byte_tx
  import bcd_uart_pkg::*;
#(
  parameter int CLK_DIV = 1875
)(
  input  logic       iclk,
  input  logic       reset,
  input  logic       i_valid,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_ready
);

  localparam int            TW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(CLK_DIV - 1);

  tx_state_t     state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [7:0]    shreg, shreg_n;
  logic [2:0]    bitn, bitn_n;
  logic          tick;

  assign tick = (timer == '0);

  // state and bit datapath registers
  always_ff @(posedge iclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      timer <= '0;
      shreg <= '0;
      bitn  <= '0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      shreg <= shreg_n;
      bitn  <= bitn_n;
    end
  end

  // bit timing: each bit lasts until the down-counter reaches zero
  always_comb begin
    state_n = state;
    timer_n = timer;
    shreg_n = shreg;
    bitn_n  = bitn;
    unique case (state)
      IDLE, NEXT: begin
        if (i_valid) begin
          state_n = START;
          timer_n = RELOAD;
          shreg_n = i_byte;
        end else begin
          state_n = IDLE;
        end
      end
      START: begin
        if (tick) begin
          state_n = DATA;
          timer_n = RELOAD;
          bitn_n  = '0;
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          timer_n = RELOAD;
          if (bitn == 3'd7) begin
            state_n = STOP;
          end else begin
            bitn_n  = bitn + 3'd1;
            shreg_n = {1'b0, shreg[7:1]};
          end
        end else begin
          timer_n = timer - TW'(1);
        end
      end
      STOP: begin
        if (tick) state_n = NEXT;
        else      timer_n = timer - TW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  // line level is decoded from state so reset forces it high at once
  always_comb begin
    o_tx = 1'b1;
    if (state == START)     o_tx = 1'b0;
    else if (state == DATA) o_tx = shreg[0];
  end

  assign o_ready = (state == IDLE) || (state == NEXT);

endmodule

// File: rtl/bcd_uart_tx.sv
// Sends a snapshot of a DIGITS-long BCD number as ASCII over UART, MSB digit
// first, optionally followed by CR LF. Messages start on i_start or, with
// auto mode, whenever the number differs from the last one sent. A request
// arriving mid-message is remembered (depth one) and serviced right after.
module bcd_uart_tx
  import bcd_uart_pkg::*;
#(
  parameter int DIGITS    = 8,
  parameter int CLK_DIV   = 1875,
  parameter int TERM_MODE = 1
)(
  input  logic         iclk,
  input  logic         reset,
  bcd_uart_tx_if.slave bus
);

  localparam int            F        = DIGITS + 2 * TERM_MODE;
  localparam int            IW       = (F > 1) ? $clog2(F) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(F - 1);

  // message-level state: IDLE, or DATA while a message is in flight
  tx_state_t              msg_state, msg_state_n;
  logic [DIGITS-1:0][3:0] snap, last_snap, sel_num;
  logic [IW-1:0]          idx, sel_idx;
  logic                   pending, bad, num_bad;
  logic                   req, char_end, done, advance, can_accept, accept;
  logic                   tx_valid, tx_ready;
  logic [7:0]             tx_byte;

  assign req        = bus.i_start || (bus.i_auto_en && (bus.i_num != last_snap));
  // while a message is active the byte sender is only ready in its gap cycle
  assign char_end   = (msg_state == DATA) && tx_ready;
  assign done       = char_end && (idx == LAST_IDX);
  assign advance    = char_end && (idx != LAST_IDX);
  // the done cycle doubles as an idle cycle so a pending request follows at once
  assign can_accept = (msg_state == IDLE) || done;
  assign accept     = can_accept && (req || pending);
  assign tx_valid   = accept || advance;

  // message state register
  always_ff @(posedge iclk or negedge reset) begin
    if (!reset) msg_state <= IDLE;
    else        msg_state <= msg_state_n;
  end

  // enter on an accepted request, leave after the last stop bit
  always_comb begin
    msg_state_n = msg_state;
    if (accept)    msg_state_n = DATA;
    else if (done) msg_state_n = IDLE;
  end

  // any live digit outside BCD range
  always_comb begin
    num_bad = 1'b0;
    for (int k = 0; k < DIGITS; k++)
      if (bus.i_num[k] > 4'd9) num_bad = 1'b1;
  end

  // snapshot, character index, pending request and sticky bad flag
  always_ff @(posedge iclk or negedge reset) begin
    if (!reset) begin
      snap      <= '0;
      last_snap <= '0;
      idx       <= '0;
      pending   <= 1'b0;
      bad       <= 1'b0;
    end else if (accept) begin
      snap      <= bus.i_num;
      last_snap <= bus.i_num;
      idx       <= '0;
      pending   <= 1'b0;
      bad       <= num_bad;
    end else begin
      if (advance)              idx     <= idx + IW'(1);
      if (req && !can_accept)   pending <= 1'b1;
    end
  end

  // the first character comes straight from i_num since the snapshot is
  // written on the same edge; later characters read the frozen snapshot
  assign sel_num = accept ? bus.i_num : snap;
  assign sel_idx = accept ? '0 : (idx + IW'(1));

  // character position to ASCII: digits MSB first, then CR, LF
  always_comb begin
    tx_byte = ASCII_LF;
    for (int k = 0; k < DIGITS; k++)
      if (sel_idx == IW'(DIGITS - 1 - k)) tx_byte = bcd_to_ascii(sel_num[k]);
    if ((TERM_MODE != 0) && (sel_idx == IW'(DIGITS))) tx_byte = ASCII_CR;
  end

  uart_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte (
    .iclk    (iclk),
    .reset   (reset),
    .i_valid (tx_valid),
    .i_byte  (tx_byte),
    .o_tx    (bus.o_tx),
    .o_ready (tx_ready)
  );

  assign bus.o_busy = (msg_state == DATA) && !done;
  assign bus.o_done = done;
  assign bus.o_bad  = bad;

endmodule

// File: tb/tb_bcd_uart_tx.sv
// Bench for bcd_uart_tx: two instances (with and without CR/LF) share the
// same stimulus. Each has a message-level reference model that predicts the
// line waveform, busy/done per cycle, and pushes expected characters and
// bad flags into queues popped by a UART decoder and a done monitor.
module tb_bcd_uart_tx;

  localparam int DIG = 8;
  localparam int CD  = 4;
  localparam int L1  = (DIG + 2) * 10 * CD + DIG + 1;

  logic                iclk    = 1'b0;
  logic                reset   = 1'b1;
  logic [DIG-1:0][3:0] num     = '0;
  logic                start   = 1'b0;
  logic                auto_en = 1'b0;
  int                  errors  = 0;
  int                  checks  = 0;

  always #5 iclk = ~iclk;

  task automatic chk(input int inst, input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL u%0d %s: got %b expected %b at %0t", inst, name, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int TM  = (g == 0) ? 1 : 0;
    localparam int F   = DIG + 2 * TM;
    localparam int L   = F * 10 * CD + F - 1;
    localparam int CPC = 10 * CD + 1;

    bcd_uart_tx_if #(.DIGITS(DIG)) bus ();
    assign bus.i_num     = num;
    assign bus.i_start   = start;
    assign bus.i_auto_en = auto_en;

    bcd_uart_tx #(.DIGITS(DIG), .CLK_DIV(CD), .TERM_MODE(TM)) dut (
      .iclk  (iclk),
      .reset (reset),
      .bus   (bus)
    );

    bit                  m_act  = 1'b0;
    bit                  m_pend = 1'b0;
    int                  m_k    = 0;
    logic [DIG-1:0][3:0] m_last = '0;
    logic [7:0]          m_msg [F];
    logic [7:0]          exp_q [$];
    bit                  bad_q [$];
    bit                  can, rq, bd;
    logic                etx, ebusy, edone;
    int                  pos, bsel;
    bit                  dec_on  = 1'b0;
    int                  dec_cnt = 0;
    logic [7:0]          dec_byte, e_byte;
    bit                  e_bad;

    // model: a message occupies L cycles plus one done cycle
    initial forever begin
      @(posedge iclk);
      if (!reset) begin
        m_act = 0; m_pend = 0; m_last = '0;
        exp_q.delete(); bad_q.delete();
      end else begin
        can = !m_act || (m_k == L + 1);
        rq  = start || (auto_en && (num != m_last));
        if (can && (rq || m_pend)) begin
          bd = 0;
          for (int j = 0; j < DIG; j++) begin
            m_msg[j] = (num[DIG-1-j] > 4'd9) ? 8'h3F : (8'h30 + {4'h0, num[DIG-1-j]});
            if (num[DIG-1-j] > 4'd9) bd = 1;
          end
          for (int j = DIG; j < F; j++) m_msg[j] = (j == DIG) ? 8'h0D : 8'h0A;
          for (int j = 0; j < F; j++) exp_q.push_back(m_msg[j]);
          bad_q.push_back(bd);
          m_last = num; m_pend = 0; m_act = 1; m_k = 1;
        end else begin
          if (!can && rq) m_pend = 1;
          if (m_act) begin
            if (m_k == L + 1) m_act = 0;
            else              m_k++;
          end
        end
      end
    end

    // per-cycle waveform check, UART decoder and done/bad monitor
    initial forever begin
      @(negedge iclk);
      etx = 1'b1; ebusy = 1'b0; edone = 1'b0;
      if (reset && m_act) begin
        if (m_k <= L) begin
          ebusy = 1'b1;
          pos   = m_k - 1;
          bsel  = (pos % CPC) / CD;
          if (bsel == 0)      etx = 1'b0;
          else if (bsel <= 8) etx = m_msg[pos / CPC][bsel - 1];
        end else begin
          edone = 1'b1;
        end
      end
      chk(g, "tx", bus.o_tx, etx);
      chk(g, "busy", bus.o_busy, ebusy);
      chk(g, "done", bus.o_done, edone);

      if (reset && bus.o_done) begin
        checks++;
        if (bad_q.size() == 0) begin
          errors++;
          $display("FAIL u%0d bad: done with no message expected at %0t", g, $time);
        end else begin
          e_bad = bad_q.pop_front();
          if (bus.o_bad !== e_bad) begin
            errors++;
            $display("FAIL u%0d bad: got %b expected %b at %0t", g, bus.o_bad, e_bad, $time);
          end
        end
      end

      if (!reset) begin
        dec_on = 1'b0;
      end else if (!dec_on) begin
        if (bus.o_tx == 1'b0) begin dec_on = 1'b1; dec_cnt = 0; end
      end else begin
        dec_cnt++;
        if (dec_cnt >= CD + CD/2 && dec_cnt < 9*CD + CD/2 && ((dec_cnt - CD/2) % CD) == 0)
          dec_byte[(dec_cnt - CD/2) / CD - 1] = bus.o_tx;
        if (dec_cnt == 9*CD + CD/2) begin
          dec_on = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL u%0d char: got %02h with none expected at %0t", g, dec_byte, $time);
          end else begin
            e_byte = exp_q.pop_front();
            if (e_byte !== dec_byte || bus.o_tx !== 1'b1) begin
              errors++;
              $display("FAIL u%0d char: got %02h stop %b expected %02h stop 1 at %0t",
                       g, dec_byte, bus.o_tx, e_byte, $time);
            end
          end
        end
      end
    end
  end

  function automatic logic [DIG-1:0][3:0] rand_num(input int maxd);
    logic [DIG-1:0][3:0] r;
    for (int i = 0; i < DIG; i++) r[i] = 4'($urandom_range(maxd));
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge iclk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge iclk);
    start = 1'b0;
  endtask

  initial begin
    #1 reset = 1'b0;
    #1;
    chk(0, "rst_tx",   u[0].bus.o_tx,   1'b1);
    chk(0, "rst_busy", u[0].bus.o_busy, 1'b0);
    chk(0, "rst_done", u[0].bus.o_done, 1'b0);
    chk(0, "rst_bad",  u[0].bus.o_bad,  1'b0);
    chk(1, "rst_tx",   u[1].bus.o_tx,   1'b1);
    chk(1, "rst_bad",  u[1].bus.o_bad,  1'b0);
    cyc(3);
    reset = 1'b1;
    cyc(2);

    // digits 1..8 MSB first
    for (int i = 0; i < DIG; i++) num[i] = 4'(DIG - i);
    pulse_start();
    cyc(L1 + 5);

    // out-of-range digit, then an all-valid message clears the flag
    num = rand_num(9);
    num[3] = 4'hB;
    pulse_start();
    cyc(L1 + 5);
    num = rand_num(9);
    pulse_start();
    cyc(L1 + 5);

    // three requests while busy merge into one follow-up message
    pulse_start();
    cyc(50);
    pulse_start();
    cyc(30);
    pulse_start();
    cyc(100);
    pulse_start();
    num = rand_num(9);
    cyc(2 * L1 + 10);

    // auto mode: enabling with an unchanged number sends nothing
    num = '0;
    pulse_start();
    cyc(L1 + 5);
    auto_en = 1'b1;
    cyc(20);
    num[0] = 4'd1;
    cyc(L1 + 2000);
    auto_en = 1'b0;

    // randomized traffic
    repeat (6000) begin
      start = ($urandom_range(199) == 0);
      if ($urandom_range(299) == 0) num = rand_num(11);
      if ($urandom_range(999) == 0) auto_en = ~auto_en;
      @(negedge iclk);
    end
    start   = 1'b0;
    auto_en = 1'b0;
    cyc(2 * L1 + 10);

    // reset during a data bit of character 4
    num = rand_num(9);
    pulse_start();
    cyc(175);
    chk(0, "pre_rst_busy", u[0].bus.o_busy, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk(0, "mid_rst_tx",   u[0].bus.o_tx,   1'b1);
    chk(0, "mid_rst_busy", u[0].bus.o_busy, 1'b0);
    chk(0, "mid_rst_done", u[0].bus.o_done, 1'b0);
    chk(1, "mid_rst_tx",   u[1].bus.o_tx,   1'b1);
    chk(1, "mid_rst_busy", u[1].bus.o_busy, 1'b0);
    cyc(3);
    reset = 1'b1;
    cyc(2);
    pulse_start();
    cyc(L1 + 5);

    chk(0, "q_empty", u[0].exp_q.size() == 0, 1'b1);
    chk(1, "q_empty", u[1].exp_q.size() == 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bcd_uart_tx.md
Name: bcd_uart_tx

Overview:
- Parametrised UART transmitter for the multi-digit BCD number held in the top level.
- Generalises the fixed baud prescaler and single-byte transmitter into one block.
- Snapshots DIGITS BCD digits, sends them as ASCII characters, most significant digit first, with an optional CR/LF terminator.
- Sends on an explicit trigger, or automatically whenever the number changes.
- Drives the board tx line in place of the disabled byte transmitter.

Parameters:
- DIGITS, 8, number of BCD digits per message (1..16).
- CLK_DIV, 1875, iclk cycles per UART bit (27 MHz / 1875 = 14400 baud); benches use 4.
- TERM_MODE, 1, 1 = append 0x0D 0x0A after the digits; 0 = digits only.

Ports:
- iclk  in  1  system clock, 27 MHz.
- reset  in  1  asynchronous, active-low reset.
- i_num  in  [3:0] x DIGITS  BCD digits; index DIGITS-1 is most significant.
- i_start  in  1  request one message, sampled on the rising edge.
- i_auto_en  in  1  1 = send a message whenever i_num differs from the last sent snapshot.
- o_tx  out  1  UART line, idle high.
- o_busy  out  1  high while a message is in flight.
- o_done  out  1  one-cycle pulse when the last stop bit completes.
- o_bad  out  1  sticky: a digit > 9 occurred in the current or last message.

Behaviour:
- Reset (async assert, sync release): o_tx=1, o_busy=0, o_done=0, o_bad=0.
  - Also: state IDLE, pending=0, last-sent snapshot = all zeros.
- Reset mid-frame: o_tx returns high immediately; the partial character is abandoned and no o_done is issued.
- Request = i_start OR (i_auto_en AND i_num != last snapshot).
- IDLE with a request:
  - Next edge: i_num is copied into the snapshot and into the last snapshot.
  - o_busy=1, o_bad cleared, then set if any snapshot digit > 9.
  - Enter START; o_tx goes low in the cycle after the request edge.
- States:
  - IDLE.
  - START: o_tx=0 for CLK_DIV cycles.
  - DATA: 8 bits, LSB first, CLK_DIV cycles each.
  - STOP: o_tx=1 for CLK_DIV cycles.
  - NEXT: one cycle, advances the character index and returns to START, or finishes.
- NEXT does not stretch the stop bit; the inter-character gap is exactly one iclk cycle.
- Character sequence, index 0..F-1, F = DIGITS + 2*TERM_MODE:
  - Digit characters, DIGITS-1 down to 0: 0x30+d for d <= 9, 0x3F ('?') for d > 9.
  - Then 0x0D, 0x0A when TERM_MODE=1.
- Bit timer: down-counter of width clog2(CLK_DIV), reloaded to CLK_DIV-1 at each bit start; the bit ends at 0.
- After STOP of character F-1:
  - o_done=1 for one cycle, o_busy=0 in that same cycle, back to IDLE.
- Busy-period requests:
  - A request while busy sets pending (depth 1; further requests are merged).
  - Pending is serviced on the cycle after o_done, with a fresh snapshot.
  - An i_num change during a message never alters characters in flight.
- Timing:
  - Message length is F*(10*CLK_DIV) + (F-1) cycles, from the first start-bit cycle to the last stop-bit cycle.
  - Request-to-first-start-bit latency is 1 cycle.
- i_auto_en rising while i_num equals the last snapshot causes no transmission.

Decomposition:
- Shared package bcd_uart_pkg:
  - ASCII_ZERO=8'h30, ASCII_BAD=8'h3F, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
  - State enum tx_state_t {IDLE, START, DATA, STOP, NEXT}.
  - Function bcd_to_ascii(d).
- One sub-module: uart_byte_tx.
  - Parametrised by CLK_DIV.
  - Ports: iclk, reset, i_valid, i_byte, o_tx, o_ready.
  - Implements the START/DATA/STOP bit timing.
  - The parent holds the snapshot, character sequencer, pending flag and change detector.

Test Plan:
- DIGITS=8, CLK_DIV=4, TERM_MODE=1, i_num=1,2,3,4,5,6,7,8 (index 7..0), i_start pulse:
  - UART decoder sees 0x31..0x38, 0x0D, 0x0A.
  - o_busy high for 10*40+9 = 409 cycles, followed by a single o_done pulse.
- Digit 3 = 0xB, TERM_MODE=0:
  - The fourth-from-last character is 0x3F.
  - o_bad = 1 after the message; it clears on the next start with all digits valid.
- i_start pulsed 3 times while busy:
  - Exactly one extra message follows, starting 1 cycle after o_done.
  - It carries the i_num value present at that cycle.
- i_auto_en=1, i_num changes from 00000000 to 00000001:
  - One message "00000001\r\n" is sent.
  - Holding i_num constant for 2000 cycles produces no further traffic.
- reset asserted during the DATA bit of character 4:
  - o_tx=1 and o_busy=0 within the same cycle, with no o_done.
  - After release, a new i_start sends the full message from the first character.
- CLK_DIV=1875 (gate-level smoke test): each bit low/high period measures 1875 iclk cycles ±0.
